axi_burst_addr_gen: RTL and testbench

- Slave-side AXI4 burst address generator.
- Accepts one AW or AR command (id, addr, len, size, burst) and emits one beat descriptor per transfer: address, byte-lane offset, beat index, last flag.
- Sits directly downstream of the DUT's AXI address channel and upstream of the slave memory / W-R data path.
- Widths come from the shared params_pkg.

---
 rtl/axi_burst_pkg.sv | 26 ++
 rtl/params_pkg.sv | 7 +
 rtl/axi_burst_addr_gen_if.sv | 37 +++
 rtl/axi_next_addr.sv | 28 ++
 rtl/axi_burst_addr_gen.sv | 154 +++++++++++++++
 tb/tb_axi_burst_addr_gen.sv | 369 ++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/axi_burst_pkg.sv
// Types shared by the AXI burst address generator and its next-address helper.
package axi_burst_pkg;
    import params_pkg::*;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [AXI_LEN_WIDTH-1:0]  len;
        logic [2:0]                size;
        burst_t                    burst;
    } cmd_t;

    localparam int LANE_WIDTH = $clog2(AXI_DATA_WIDTH / 8);
endpackage

// File: rtl/params_pkg.sv
// Project-wide AXI bus widths shared by the address generators and data paths.
package params_pkg;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_LEN_WIDTH  = 8;
endpackage

// File: rtl/axi_burst_addr_gen_if.sv
// Command-in / beat-descriptor-out bundle of the burst address generator.
interface axi_burst_addr_gen_if #(
    parameter int ID_WIDTH   = params_pkg::AXI_ID_WIDTH,
    parameter int ADDR_WIDTH = params_pkg::AXI_ADDR_WIDTH,
    parameter int LEN_WIDTH  = params_pkg::AXI_LEN_WIDTH,
    parameter int LANE_W     = axi_burst_pkg::LANE_WIDTH
);
    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic [ID_WIDTH-1:0]   i_cmd_id;
    logic [ADDR_WIDTH-1:0] i_cmd_addr;
    logic [LEN_WIDTH-1:0]  i_cmd_len;
    logic [2:0]            i_cmd_size;
    logic [1:0]            i_cmd_burst;
    logic                  o_beat_valid;
    logic                  i_beat_ready;
    logic [ID_WIDTH-1:0]   o_beat_id;
    logic [ADDR_WIDTH-1:0] o_beat_addr;
    logic [LANE_W-1:0]     o_beat_lane;
    logic [LEN_WIDTH-1:0]  o_beat_idx;
    logic                  o_beat_last;
    logic                  o_err;

    modport slave (
        input  i_cmd_valid, i_cmd_id, i_cmd_addr, i_cmd_len, i_cmd_size, i_cmd_burst,
        input  i_beat_ready,
        output o_cmd_ready, o_beat_valid, o_beat_id, o_beat_addr, o_beat_lane,
        output o_beat_idx, o_beat_last, o_err
    );

    modport master (
        output i_cmd_valid, i_cmd_id, i_cmd_addr, i_cmd_len, i_cmd_size, i_cmd_burst,
        output i_beat_ready,
        input  o_cmd_ready, o_beat_valid, o_beat_id, o_beat_addr, o_beat_lane,
        input  o_beat_idx, o_beat_last, o_err
    );
endinterface

// File: rtl/axi_next_addr.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts; shared with the read side.
module axi_next_addr
    import axi_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = params_pkg::AXI_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [2:0]            i_size,
    input  burst_t                i_burst,
    input  logic [ADDR_WIDTH-1:0] i_wrap_lower,
    input  logic [ADDR_WIDTH-1:0] i_wrap_size,
    output logic [ADDR_WIDTH-1:0] o_next_addr
);
    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr;

    always_comb begin
        bytes   = ADDR_WIDTH'(1) << i_size;
        aligned = i_addr & ~(bytes - ADDR_WIDTH'(1));
        incr    = aligned + bytes;
        case (i_burst)
            FIXED:   o_next_addr = i_addr;
            WRAP:    o_next_addr = (incr == i_wrap_lower + i_wrap_size) ? i_wrap_lower : incr;
            default: o_next_addr = incr;   // INCR, and RSVD behaves as INCR
        endcase
    end
endmodule

// File: rtl/axi_burst_addr_gen.sv
// Slave-side AXI4 burst address generator: one command in, one beat descriptor per transfer out.
// Optional illegal-command flag built only when AXI_BURST_CHECK_EN is defined.
module axi_burst_addr_gen
    import axi_burst_pkg::*;
#(
    parameter int ID_WIDTH   = params_pkg::AXI_ID_WIDTH,
    parameter int ADDR_WIDTH = params_pkg::AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = params_pkg::AXI_DATA_WIDTH,
    parameter int LEN_WIDTH  = params_pkg::AXI_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    axi_burst_addr_gen_if.slave  bus
);
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    state_t                state_q, state_d;
    cmd_t                  cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] lower_q, lower_d;
    logic [ADDR_WIDTH-1:0] wsize_q, wsize_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] next_addr;

    logic                  cmd_ready;
    logic                  beat_valid;
    logic                  beat_last;
    logic                  accept;
    logic [2:0]            size_eff;
    logic [ADDR_WIDTH-1:0] cmd_bytes;
    logic [ADDR_WIDTH-1:0] cmd_wsize;
    logic [ADDR_WIDTH-1:0] cmd_lower;

    // Incoming command geometry; oversized transfers are clamped to the bus width.
    always_comb begin
        size_eff  = (bus.i_cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : bus.i_cmd_size;
        cmd_bytes = ADDR_WIDTH'(1) << size_eff;
        cmd_wsize = cmd_bytes * (ADDR_WIDTH'(bus.i_cmd_len) + ADDR_WIDTH'(1));
        cmd_lower = bus.i_cmd_addr & ~(cmd_wsize - ADDR_WIDTH'(1));
    end

    // Gating with reset keeps the handshakes dead in the reset cycle itself.
    assign cmd_ready  = (state_q == ST_IDLE) && !reset;
    assign beat_valid = (state_q == ST_BURST) && !reset;
    assign beat_last  = beat_valid && (idx_q == cmd_q.len);
    assign accept     = cmd_ready && bus.i_cmd_valid;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        lower_d = lower_q;
        wsize_d = wsize_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_d.id    = bus.i_cmd_id;
                    cmd_d.addr  = bus.i_cmd_addr;
                    cmd_d.len   = bus.i_cmd_len;
                    cmd_d.size  = size_eff;
                    cmd_d.burst = burst_t'(bus.i_cmd_burst);
                    addr_d      = bus.i_cmd_addr;
                    lower_d     = cmd_lower;
                    wsize_d     = cmd_wsize;
                    idx_d       = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat_valid && bus.i_beat_ready) begin
                    if (beat_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d  = idx_q + LEN_WIDTH'(1);
                        addr_d = next_addr;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    axi_next_addr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_next_addr (
        .i_addr       (addr_q),
        .i_size       (cmd_q.size),
        .i_burst      (cmd_q.burst),
        .i_wrap_lower (lower_q),
        .i_wrap_size  (wsize_q),
        .o_next_addr  (next_addr)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            lower_q <= '0;
            wsize_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            lower_q <= lower_d;
            wsize_q <= wsize_d;
            idx_q   <= idx_d;
        end
    end

`ifdef AXI_BURST_CHECK_EN
    logic        err_q, err_d;
    logic        illegal;
    logic        is_wrap;
    logic [31:0] span_end;

    always_comb begin
        is_wrap  = (bus.i_cmd_burst == 2'b10);
        // Byte offset one past the burst's final byte, relative to its 4 KB page.
        span_end = 32'(bus.i_cmd_addr[11:0] & ~12'(cmd_bytes - ADDR_WIDTH'(1))) + 32'(cmd_wsize);
        illegal  = (is_wrap && !(bus.i_cmd_len inside {LEN_WIDTH'(1), LEN_WIDTH'(3),
                                                        LEN_WIDTH'(7), LEN_WIDTH'(15)}))
                || (is_wrap && ((bus.i_cmd_addr & (cmd_bytes - ADDR_WIDTH'(1))) != '0))
                || (bus.i_cmd_size > 3'(MAX_SIZE))
                || ((bus.i_cmd_burst == 2'b01) && (span_end > 32'd4096))
                || (bus.i_cmd_burst == 2'b11);
        err_d    = err_q | (accept & illegal);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

    assign bus.o_cmd_ready  = cmd_ready;
    assign bus.o_beat_valid = beat_valid;
    assign bus.o_beat_id    = cmd_q.id;
    assign bus.o_beat_addr  = addr_q;
    assign bus.o_beat_lane  = addr_q[MAX_SIZE-1:0];
    assign bus.o_beat_idx   = idx_q;
    assign bus.o_beat_last  = beat_last;
endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen: hand-computed beat sequences, stalls, resets, error flag.
module tb_axi_burst_addr_gen;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef AXI_BURST_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    axi_burst_addr_gen_if bus ();

    axi_burst_addr_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // {valid, id, addr, lane, idx, last}
    function automatic logic [47:0] observed();
        return {bus.o_beat_valid, bus.o_beat_id, bus.o_beat_addr, bus.o_beat_lane,
                bus.o_beat_idx, bus.o_beat_last};
    endfunction

    function automatic logic [47:0] beat_word(input logic [3:0] id, input logic [31:0] addr,
                                              input logic [7:0] idx, input logic last);
        return {1'b1, id, addr, addr[1:0], idx, last};
    endfunction

    // Called at a negedge; returns at the negedge right after the command handshake.
    task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id);
        int waited = 0;
        while (bus.o_cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (waited >= 20) begin
            miscompares++;
            $display("FAIL cmd_ready wait: ready %b after %0d cycles, want 1", bus.o_cmd_ready, waited);
        end
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_addr  = addr;
        bus.i_cmd_len   = len;
        bus.i_cmd_size  = size;
        bus.i_cmd_burst = burst;
        bus.i_cmd_id    = id;
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
    endtask

    // Consumes the remainder of a burst with ready held high; ends one negedge after the last beat.
    task automatic drain_burst();
        int n = 0;
        bus.i_beat_ready = 1'b1;
        while (!(bus.o_beat_valid === 1'b1 && bus.o_beat_last === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 300) begin
            miscompares++;
            $display("FAIL drain: no last beat within %0d cycles", n);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_cmd_valid  = 1'b0;
        bus.i_beat_ready = 1'b0;
        bus.i_cmd_id     = '0;
        bus.i_cmd_addr   = '0;
        bus.i_cmd_len    = '0;
        bus.i_cmd_size   = '0;
        bus.i_cmd_burst  = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.o_cmd_ready, observed(), bus.o_err} !== 50'h0) begin
            miscompares++;
            $display("FAIL reset held: ready %b beat %h err %b, want all 0",
                     bus.o_cmd_ready, observed(), bus.o_err);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.o_cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset release ready: got %b want 1", bus.o_cmd_ready);
        end
        @(negedge clk);
        vectors++;
        if ({bus.o_cmd_ready, observed(), bus.o_err} !== {1'b1, 49'h0}) begin
            miscompares++;
            $display("FAIL idle after reset: ready %b beat %h err %b, want ready 1 rest 0",
                     bus.o_cmd_ready, observed(), bus.o_err);
        end
    endtask

    task automatic test_incr();
        logic [31:0] exp_addr [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        logic [47:0] exp;
        bus.i_beat_ready = 1'b1;
        send_cmd(32'h1000, 8'd3, 3'd2, 2'b01, 4'h5);
        for (int i = 0; i < 4; i++) begin
            exp = beat_word(4'h5, exp_addr[i], 8'(i), i == 3);
            vectors++;
            if ({bus.o_cmd_ready, observed()} !== {1'b0, exp}) begin
                miscompares++;
                $display("FAIL incr beat %0d: ready %b beat %h, want ready 0 beat %h",
                         i, bus.o_cmd_ready, observed(), exp);
            end
            @(negedge clk);
        end
        vectors++;
        if ({bus.o_beat_valid, bus.o_cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL incr end: valid %b ready %b, want 0 1", bus.o_beat_valid, bus.o_cmd_ready);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
        logic [47:0] exp;
        bus.i_beat_ready = 1'b1;
        send_cmd(32'h38, 8'd3, 3'd2, 2'b10, 4'h9);
        for (int i = 0; i < 4; i++) begin
            exp = beat_word(4'h9, exp_addr[i], 8'(i), i == 3);
            vectors++;
            if (observed() !== exp) begin
                miscompares++;
                $display("FAIL wrap beat %0d: got %h want %h", i, observed(), exp);
            end
            @(negedge clk);
        end
        vectors++;
        if (bus.o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap legal err: got %b want 0", bus.o_err);
        end
    endtask

    task automatic test_fixed_stall();
        logic        pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [47:0] exp;
        int          hs = 0;
        bus.i_beat_ready = 1'b0;
        send_cmd(32'h200, 8'd2, 3'd2, 2'b00, 4'h2);
        for (int k = 0; k < 5; k++) begin
            bus.i_beat_ready = pat[k];
            exp = beat_word(4'h2, 32'h200, 8'(hs), hs == 2);
            vectors++;
            if (observed() !== exp) begin
                miscompares++;
                $display("FAIL fixed cycle %0d: got %h want %h", k, observed(), exp);
            end
            if (pat[k]) hs++;
            @(negedge clk);
        end
        vectors++;
        if ({bus.o_beat_valid, bus.o_cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL fixed after 3 handshakes: valid %b ready %b, want 0 1",
                     bus.o_beat_valid, bus.o_cmd_ready);
        end
        bus.i_beat_ready = 1'b1;
    endtask

    task automatic test_unaligned();
        logic [47:0] exp;
        bus.i_beat_ready = 1'b1;
        send_cmd(32'h1003, 8'd1, 3'd2, 2'b01, 4'h3);
        exp = beat_word(4'h3, 32'h1003, 8'd0, 1'b0);
        vectors++;
        if (observed() !== exp) begin
            miscompares++;
            $display("FAIL unaligned beat 0: got %h want %h", observed(), exp);
        end
        @(negedge clk);
        exp = beat_word(4'h3, 32'h1004, 8'd1, 1'b1);
        vectors++;
        if (observed() !== exp) begin
            miscompares++;
            $display("FAIL unaligned beat 1: got %h want %h", observed(), exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [47:0] exp;
        bus.i_beat_ready = 1'b1;
        send_cmd(32'h2000, 8'd7, 3'd2, 2'b01, 4'h7);
        @(negedge clk);
        exp = beat_word(4'h7, 32'h2004, 8'd1, 1'b0);
        vectors++;
        if (observed() !== exp) begin
            miscompares++;
            $display("FAIL reset_mid beat 1: got %h want %h", observed(), exp);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.o_cmd_ready, observed()} !== 49'h0) begin
            miscompares++;
            $display("FAIL reset_mid during reset: ready %b beat %h, want all 0",
                     bus.o_cmd_ready, observed());
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus.o_cmd_ready, bus.o_beat_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_mid release: ready %b valid %b, want 1 0",
                     bus.o_cmd_ready, bus.o_beat_valid);
        end
        send_cmd(32'h80, 8'd0, 3'd2, 2'b01, 4'h1);
        exp = beat_word(4'h1, 32'h80, 8'd0, 1'b1);
        vectors++;
        if (observed() !== exp) begin
            miscompares++;
            $display("FAIL reset_mid single beat: got %h want %h", observed(), exp);
        end
        @(negedge clk);
        vectors++;
        if ({bus.o_beat_valid, bus.o_cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_mid single end: valid %b ready %b, want 0 1",
                     bus.o_beat_valid, bus.o_cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1 [4] = '{32'h4, 32'h5, 32'h6, 32'h7};
        logic [31:0] a2 [4] = '{32'h16, 32'h10, 32'h12, 32'h14};
        logic [47:0] exp;
        bus.i_beat_ready = 1'b1;
        send_cmd(32'h4, 8'd3, 3'd0, 2'b10, 4'hA);
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, 4'hA, a1[i], a1[i][1:0], 8'(i), i == 3};
            vectors++;
            if (observed() !== exp) begin
                miscompares++;
                $display("FAIL b2b first beat %0d: got %h want %h", i, observed(), exp);
            end
            @(negedge clk);
        end
        // Bubble cycle: idle, ready, no beat.
        vectors++;
        if ({bus.o_beat_valid, bus.o_cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b bubble: valid %b ready %b, want 0 1", bus.o_beat_valid, bus.o_cmd_ready);
        end
        send_cmd(32'h16, 8'd3, 3'd1, 2'b10, 4'hB);
        for (int i = 0; i < 4; i++) begin
            exp = beat_word(4'hB, a2[i], 8'(i), i == 3);
            vectors++;
            if (observed() !== exp) begin
                miscompares++;
                $display("FAIL b2b second beat %0d: got %h want %h", i, observed(), exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_err();
        logic [31:0] exp_addr [4] = '{32'hFF8, 32'hFFC, 32'h1000, 32'h1004};
        logic [47:0] exp;
        bus.i_beat_ready = 1'b1;
        send_cmd(32'h40, 8'd2, 3'd2, 2'b10, 4'h4);
        vectors++;
        if (bus.o_err !== ERR_EN) begin
            miscompares++;
            $display("FAIL err wrap len2: got %b want %b", bus.o_err, ERR_EN);
        end
        drain_burst();
        send_cmd(32'h100, 8'd0, 3'd2, 2'b01, 4'h4);
        drain_burst();
        vectors++;
        if (bus.o_err !== ERR_EN) begin
            miscompares++;
            $display("FAIL err sticky: got %b want %b", bus.o_err, ERR_EN);
        end
        do_reset(2);
        @(negedge clk);
        vectors++;
        if (bus.o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err cleared by reset: got %b want 0", bus.o_err);
        end
        send_cmd(32'hFF8, 8'd3, 3'd2, 2'b01, 4'h6);
        vectors++;
        if (bus.o_err !== ERR_EN) begin
            miscompares++;
            $display("FAIL err 4k cross: got %b want %b", bus.o_err, ERR_EN);
        end
        for (int i = 0; i < 4; i++) begin
            exp = beat_word(4'h6, exp_addr[i], 8'(i), i == 3);
            vectors++;
            if (observed() !== exp) begin
                miscompares++;
                $display("FAIL 4k cross beat %0d: got %h want %h", i, observed(), exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_size_clamp_and_top();
        logic [47:0] exp;
        bus.i_beat_ready = 1'b1;
        // 16-byte transfers on a 4-byte bus step by 4.
        send_cmd(32'h100, 8'd1, 3'd4, 2'b01, 4'hC);
        exp = beat_word(4'hC, 32'h100, 8'd0, 1'b0);
        vectors++;
        if (observed() !== exp) begin
            miscompares++;
            $display("FAIL clamp beat 0: got %h want %h", observed(), exp);
        end
        @(negedge clk);
        exp = beat_word(4'hC, 32'h104, 8'd1, 1'b1);
        vectors++;
        if (observed() !== exp) begin
            miscompares++;
            $display("FAIL clamp beat 1: got %h want %h", observed(), exp);
        end
        @(negedge clk);
        send_cmd(32'hFFFF_FFFC, 8'd1, 3'd2, 2'b11, 4'hD);
        @(negedge clk);
        exp = beat_word(4'hD, 32'h0, 8'd1, 1'b1);
        vectors++;
        if (observed() !== exp) begin
            miscompares++;
            $display("FAIL addr space wrap beat 1: got %h want %h", observed(), exp);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_stall();
        test_unaligned();
        test_reset_mid();
        test_back_to_back();
        test_err();
        test_size_clamp_and_top();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
